frontend_cmd_issuer: RTL and testbench

Initiator side of the frontend↔backend command/data protocol. It sits between the request scheduler and the backend controller. It buffers scheduler requests and issues them on the backend command channel. It supplies write data whenever the backend pulses its read-enable, and it collects returned read data with flow control. Read credits guarantee the read-return buffer can never overflow.

---
 rtl/frontend_cmd_issuer_pkg.sv | 28 ++
 rtl/frontend_cmd_issuer_if.sv | 57 +++++
 rtl/frontend_cmd_issuer_sync_fifo.sv | 47 ++++
 rtl/frontend_cmd_issuer.sv | 126 ++++++++++++
 tb/tb_frontend_cmd_issuer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/frontend_cmd_issuer_pkg.sv
// Shared widths, command-word field layout and error-bit positions for the
// frontend command issuer.
package frontend_if_pkg;

    localparam int DQ_BITS           = 16;
    localparam int FRONTEND_CMD_BITS = 32;

    localparam int CMD_WRITE_BIT = FRONTEND_CMD_BITS - 1;
    localparam int CMD_BANK_MSB  = 30;
    localparam int CMD_BANK_LSB  = 28;
    localparam int CMD_ROW_MSB   = 27;
    localparam int CMD_ROW_LSB   = 12;
    localparam int CMD_COL_MSB   = 11;
    localparam int CMD_COL_LSB   = 0;

    typedef struct packed {
        logic        write;
        logic [2:0]  bank;
        logic [15:0] row;
        logic [11:0] col;
    } cmd_t;

    typedef enum logic [0:0] {
        ERR_WDATA_UNDERFLOW  = 1'b0,
        ERR_RDATA_UNEXPECTED = 1'b1
    } err_bit_e;

endpackage

// File: rtl/frontend_cmd_issuer_if.sv
// Scheduler and backend signals of the command issuer. The issuer itself uses
// the master view; the surrounding scheduler/backend use the slave view.
interface frontend_cmd_issuer_if
    import frontend_if_pkg::*;
#(
    parameter int DATA_W = DQ_BITS * 8,
    parameter int CMD_W  = FRONTEND_CMD_BITS,
    parameter int CNT_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [CMD_W-1:0]  req_cmd;
    logic [DATA_W-1:0] req_wdata;

    logic              o_frontend_command_valid;
    logic [CMD_W-1:0]  o_frontend_command;
    logic              i_backend_controller_ready;
    logic              i_backend_controller_ren;
    logic [DATA_W-1:0] o_frontend_write_data;

    logic [DATA_W-1:0] i_backend_read_data;
    logic              i_backend_read_data_valid;
    logic              o_frontend_controller_ready;
    logic              o_backend_controller_stall;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    logic [CNT_W-1:0]  o_outstanding_reads;
    logic [1:0]        o_err;

    modport master (
        input  req_valid, req_cmd, req_wdata,
        input  i_backend_controller_ready, i_backend_controller_ren,
        input  i_backend_read_data, i_backend_read_data_valid,
        input  rsp_ready,
        output req_ready,
        output o_frontend_command_valid, o_frontend_command, o_frontend_write_data,
        output o_frontend_controller_ready, o_backend_controller_stall,
        output rsp_valid, rsp_rdata,
        output o_outstanding_reads, o_err
    );

    modport slave (
        output req_valid, req_cmd, req_wdata,
        output i_backend_controller_ready, i_backend_controller_ren,
        output i_backend_read_data, i_backend_read_data_valid,
        output rsp_ready,
        input  req_ready,
        input  o_frontend_command_valid, o_frontend_command, o_frontend_write_data,
        input  o_frontend_controller_ready, o_backend_controller_stall,
        input  rsp_valid, rsp_rdata,
        input  o_outstanding_reads, o_err
    );

endinterface

// File: rtl/frontend_cmd_issuer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// Head data reads 0 while empty; push when full and pop when empty are ignored.
module frontend_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             power_on_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never observed while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/frontend_cmd_issuer.sv
// Frontend initiator: queues scheduler requests, issues commands to the backend
// under read-credit control, serves write beats and buffers read returns.
module frontend_cmd_issuer
    import frontend_if_pkg::*;
#(
    parameter  int DATA_W       = DQ_BITS * 8,
    parameter  int CMD_W        = FRONTEND_CMD_BITS,
    parameter  int WRITE_BIT    = CMD_W - 1,
    parameter  int CMD_DEPTH    = 4,
    parameter  int WDATA_DEPTH  = 4,
    parameter  int RDATA_DEPTH  = 4,
    parameter  int STALL_THRESH = 3,
    localparam int CNT_W        = $clog2(RDATA_DEPTH) + 1
) (
    input  logic clk,
    input  logic power_on_rst_n,
    frontend_cmd_issuer_if.master bus
);

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RDATA_DEPTH);
    localparam logic [CNT_W-1:0] STALL_LVL  = CNT_W'(STALL_THRESH);

    logic [CMD_W-1:0]                 cmd_head;
    logic [$clog2(CMD_DEPTH):0]       cmd_count;
    logic                             cmd_full;
    logic                             cmd_empty;
    logic [$clog2(WDATA_DEPTH):0]     wd_count;
    logic                             wd_full;
    logic                             wd_empty;
    logic [CNT_W-1:0]                 rd_count;
    logic                             rd_full;
    logic                             rd_empty;

    logic                             accept;
    logic                             head_is_write;
    logic                             cmd_fire;
    logic                             read_fire;
    logic                             rsp_pop;
    logic                             rd_unexpected;
    logic                             rd_push;
    logic                             wd_underflow;
    logic [CNT_W-1:0]                 outstanding;
    logic                             stall_q;
    logic [1:0]                       err_q;
    logic                             unused_counts;

    assign unused_counts = ^{cmd_count, wd_count};

    // Reads also wait for write-data space so a request is never half-accepted.
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.req_ready = !cmd_full && !wd_full;

    assign head_is_write = cmd_head[WRITE_BIT];
    assign bus.o_frontend_command_valid = !cmd_empty && (head_is_write || (outstanding < CREDIT_MAX));
    assign bus.o_frontend_command       = cmd_head;
    assign cmd_fire  = bus.o_frontend_command_valid && bus.i_backend_controller_ready;
    assign read_fire = cmd_fire && !head_is_write;

    assign wd_underflow = bus.i_backend_controller_ren && wd_empty;

    // With no read in flight every buffered beat is already accounted for.
    assign rd_unexpected = bus.i_backend_read_data_valid && (outstanding == rd_count);
    assign rd_push       = bus.i_backend_read_data_valid && !rd_unexpected;
    assign bus.o_frontend_controller_ready = !rd_full;

    assign bus.rsp_valid = !rd_empty;
    assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;

    assign bus.o_outstanding_reads        = outstanding;
    assign bus.o_backend_controller_stall = stall_q;
    assign bus.o_err                      = err_q;

    frontend_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk            (clk),
        .power_on_rst_n (power_on_rst_n),
        .push           (accept),
        .wdata          (bus.req_cmd),
        .pop            (cmd_fire),
        .rdata          (cmd_head),
        .count          (cmd_count),
        .full           (cmd_full),
        .empty          (cmd_empty)
    );

    frontend_sync_fifo #(.WIDTH(DATA_W), .DEPTH(WDATA_DEPTH)) u_wdata_fifo (
        .clk            (clk),
        .power_on_rst_n (power_on_rst_n),
        .push           (accept && bus.req_cmd[WRITE_BIT]),
        .wdata          (bus.req_wdata),
        .pop            (bus.i_backend_controller_ren),
        .rdata          (bus.o_frontend_write_data),
        .count          (wd_count),
        .full           (wd_full),
        .empty          (wd_empty)
    );

    frontend_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RDATA_DEPTH)) u_rdata_fifo (
        .clk            (clk),
        .power_on_rst_n (power_on_rst_n),
        .push           (rd_push),
        .wdata          (bus.i_backend_read_data),
        .pop            (rsp_pop),
        .rdata          (bus.rsp_rdata),
        .count          (rd_count),
        .full           (rd_full),
        .empty          (rd_empty)
    );

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            outstanding <= '0;
            stall_q     <= 1'b0;
            err_q       <= '0;
        end else begin
            unique case ({read_fire, rsp_pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            stall_q <= (rd_count >= STALL_LVL);
            if (wd_underflow)  err_q[ERR_WDATA_UNDERFLOW]  <= 1'b1;
            if (rd_unexpected) err_q[ERR_RDATA_UNEXPECTED] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frontend_cmd_issuer.sv
// Directed bench for frontend_cmd_issuer: write path, read credits, read
// backpressure, sticky errors and asynchronous reset.
module tb_frontend_cmd_issuer;

    logic clk = 1'b0;
    logic power_on_rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [127:0] beats [4];
    logic [127:0] wd_a5;
    int           guard;

    frontend_cmd_issuer_if bus ();

    frontend_cmd_issuer dut (
        .clk            (clk),
        .power_on_rst_n (power_on_rst_n),
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_valid"}, bus.o_frontend_command_valid, 0);
        check({tag, "_cmd"},       bus.o_frontend_command, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_err"},       bus.o_err, 0);
        check({tag, "_outst"},     bus.o_outstanding_reads, 0);
        check({tag, "_stall"},     bus.o_backend_controller_stall, 0);
        check({tag, "_wdata"},     bus.o_frontend_write_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        beats[0] = {4{32'h1111_1111}};
        beats[1] = {4{32'h2222_2222}};
        beats[2] = {4{32'h3333_3333}};
        beats[3] = {4{32'h4444_4444}};
        wd_a5    = {16{8'hA5}};

        bus.req_valid = 0;
        bus.req_cmd = '0;
        bus.req_wdata = '0;
        bus.i_backend_controller_ready = 0;
        bus.i_backend_controller_ren = 0;
        bus.i_backend_read_data = '0;
        bus.i_backend_read_data_valid = 0;
        bus.rsp_ready = 0;

        #12;
        check_reset_values("por");
        @(negedge clk);
        power_on_rst_n = 1'b1;
        step();
        check("por_req_ready", bus.req_ready, 1);
        check("por_rd_ready", bus.o_frontend_controller_ready, 1);

        // Single write
        bus.req_valid = 1;
        bus.req_cmd = 32'h8000_0010;
        bus.req_wdata = wd_a5;
        bus.i_backend_controller_ready = 1;
        #1;
        check("wr_c0_valid", bus.o_frontend_command_valid, 0);
        step();
        bus.req_valid = 0;
        #1;
        check("wr_c1_valid", bus.o_frontend_command_valid, 1);
        check("wr_c1_cmd", bus.o_frontend_command, 32'h8000_0010);
        step();
        check("wr_c2_valid", bus.o_frontend_command_valid, 0);
        step();
        bus.i_backend_controller_ren = 1;
        #1;
        check("wr_c3_wdata", bus.o_frontend_write_data, wd_a5);
        step();
        bus.i_backend_controller_ren = 0;
        #1;
        check("wr_after_pop_wdata", bus.o_frontend_write_data, 0);
        check("wr_err", bus.o_err, 0);

        // Read credit limit: six reads, four credits
        for (int i = 0; i < 6; i++) begin
            bus.req_cmd = 32'h0000_0100 + i;
            bus.req_valid = 1;
            #1;
            guard = 0;
            while (!bus.req_ready && guard < 20) begin
                step();
                guard++;
            end
            if (guard == 20) check("rd_req_timeout", 0, 1);
            step();
        end
        bus.req_valid = 0;
        repeat (3) step();
        check("credit_outst", bus.o_outstanding_reads, 4);
        check("credit_valid", bus.o_frontend_command_valid, 0);
        check("credit_head", bus.o_frontend_command, 32'h0000_0104);

        bus.i_backend_read_data = {4{32'h0000_00D0}};
        bus.i_backend_read_data_valid = 1;
        step();
        bus.i_backend_read_data_valid = 0;
        #1;
        check("credit_rsp_valid", bus.rsp_valid, 1);
        check("credit_rsp_data", bus.rsp_rdata, {4{32'h0000_00D0}});
        bus.rsp_ready = 1;
        step();
        bus.rsp_ready = 0;
        #1;
        check("credit_outst_pop", bus.o_outstanding_reads, 3);
        check("credit_5th_valid", bus.o_frontend_command_valid, 1);
        check("credit_5th_cmd", bus.o_frontend_command, 32'h0000_0104);
        step();
        check("credit_5th_outst", bus.o_outstanding_reads, 4);
        check("credit_6th_head", bus.o_frontend_command, 32'h0000_0105);

        // Read backpressure
        for (int i = 0; i < 3; i++) begin
            bus.i_backend_read_data = beats[i];
            bus.i_backend_read_data_valid = 1;
            step();
        end
        #1;
        check("bp_stall_early", bus.o_backend_controller_stall, 0);
        check("bp_ready_3", bus.o_frontend_controller_ready, 1);
        bus.i_backend_read_data = beats[3];
        step();
        bus.i_backend_read_data_valid = 0;
        #1;
        check("bp_stall", bus.o_backend_controller_stall, 1);
        check("bp_ready_full", bus.o_frontend_controller_ready, 0);
        check("bp_rsp_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_rdata%0d", i), bus.rsp_rdata, beats[i]);
            step();
        end
        bus.rsp_ready = 0;
        #1;
        check("bp_drained", bus.rsp_valid, 0);
        check("bp_outst", bus.o_outstanding_reads, 1);
        check("bp_cmd_empty", bus.o_frontend_command_valid, 0);

        // Write-data underflow
        bus.i_backend_controller_ren = 1;
        step();
        bus.i_backend_controller_ren = 0;
        #1;
        check("uf_wdata", bus.o_frontend_write_data, 0);
        check("uf_err", bus.o_err, 2'b01);
        repeat (2) step();
        check("uf_err_sticky", bus.o_err, 2'b01);

        // Reset mid-burst: two writes queued, one read outstanding
        bus.i_backend_controller_ready = 0;
        bus.req_valid = 1;
        bus.req_cmd = 32'h8000_0020;
        bus.req_wdata = beats[1];
        step();
        bus.req_cmd = 32'h8000_0030;
        bus.req_wdata = beats[2];
        step();
        bus.req_valid = 0;
        #1;
        check("mid_cmd_valid", bus.o_frontend_command_valid, 1);
        check("mid_cmd", bus.o_frontend_command, 32'h8000_0020);
        check("mid_wdata", bus.o_frontend_write_data, beats[1]);
        check("mid_outst", bus.o_outstanding_reads, 1);
        #2;
        power_on_rst_n = 1'b0;
        #1;
        check_reset_values("async");
        @(negedge clk);
        power_on_rst_n = 1'b1;
        step();
        check("rel_req_ready", bus.req_ready, 1);
        check("rel_cmd_valid", bus.o_frontend_command_valid, 0);
        check("rel_wdata", bus.o_frontend_write_data, 0);

        // Unexpected read data with nothing in flight
        bus.i_backend_read_data = {4{32'h0000_0BAD}};
        bus.i_backend_read_data_valid = 1;
        step();
        bus.i_backend_read_data_valid = 0;
        #1;
        check("unexp_err", bus.o_err, 2'b10);
        check("unexp_rsp_valid", bus.rsp_valid, 0);
        check("unexp_rd_ready", bus.o_frontend_controller_ready, 1);
        check("unexp_outst", bus.o_outstanding_reads, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
